// File: rtl/rv32i_pkg.sv
// +----------------------------------------------------------------------+
// | rv32i_pkg                                                            |
// | Shared types and constants for the RV32I front end.                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package rv32i_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RV32I_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_watchdog.sv
// +----------------------------------------------------------------------+
// | fetch_watchdog                                                       |
// | Counts unacknowledged request cycles; expires at TIMEOUT_CYCLES.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module fetch_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_restart,
  input  logic i_active,
  output logic o_expire
);

  localparam int unsigned c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);

  logic [c_cnt_w-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_restart) begin
      r_count <= '0;
    end else if (i_active && !o_expire) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Expires on the cycle whose increment would bring the count to the limit.
  assign o_expire = i_active && !i_restart &&
                    (r_count == c_cnt_w'(TIMEOUT_CYCLES - 1));

endmodule

`default_nettype wire

// File: rtl/instruction_fetch.sv
// +----------------------------------------------------------------------+
// | instruction_fetch                                                    |
// | RV32I fetch stage: PC, imem req/ack, branch redirect, fault capture. |
// | Optional macro IFETCH_TIMEOUT_EN adds an ack-timeout watchdog.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module instruction_fetch
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned     TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] pc,
  output logic            instr_valid,
  output logic            fault
);

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_instruction;
  logic [XLEN-1:0] r_redirect_target;
  logic            r_redirect_pending;
  logic            r_instr_valid;
  logic            r_fault;
  logic            r_imem_req;

  logic            w_misaligned;
  logic            w_timeout;
  logic [XLEN-1:0] w_pc_plus4;

  assign w_misaligned = branch_taken && (branch_target[1:0] != 2'b00);
  assign w_pc_plus4   = r_pc + 32'd4;

`ifdef IFETCH_TIMEOUT_EN
  logic w_wd_restart;

  // Count restarts whenever a request phase (FETCH or DRAIN) begins afresh.
  assign w_wd_restart = imem_ack || (r_state == ISSUE) || (r_state == FAULT) ||
                        ((r_state == FETCH) && branch_taken);

  fetch_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_fetch_watchdog (
    .clk       (clk),
    .rst       (rst),
    .i_restart (w_wd_restart),
    .i_active  (r_imem_req && !imem_ack),
    .o_expire  (w_timeout)
  );
`else
  // Without the watchdog the block waits for the ack indefinitely.
  assign w_timeout = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state            <= FETCH;
      r_pc               <= RESET_PC;
      r_instruction      <= RV32I_NOP;
      r_redirect_target  <= RESET_PC;
      r_redirect_pending <= 1'b0;
      r_instr_valid      <= 1'b0;
      r_fault            <= 1'b0;
      r_imem_req         <= 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          if (w_misaligned) begin
            r_state       <= FAULT;
            r_pc          <= branch_target;
            r_fault       <= 1'b1;
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b0;
          end else if (branch_taken && imem_ack) begin
            r_pc       <= branch_target;
            r_imem_req <= 1'b1;
          end else if (branch_taken) begin
            // Outstanding request cannot be cancelled; its word is dropped in DRAIN.
            r_redirect_pending <= 1'b1;
            r_redirect_target  <= branch_target;
            r_state            <= DRAIN;
            r_imem_req         <= 1'b1;
          end else if (imem_ack) begin
            r_instruction <= imem_rdata;
            r_instr_valid <= 1'b1;
            r_imem_req    <= 1'b0;
            r_state       <= ISSUE;
          end else if (w_timeout) begin
            r_state       <= FAULT;
            r_fault       <= 1'b1;
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b0;
          end else begin
            r_imem_req <= 1'b1;
          end
        end

        ISSUE: begin
          if (w_misaligned) begin
            r_state       <= FAULT;
            r_pc          <= branch_target;
            r_fault       <= 1'b1;
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b0;
          end else if (branch_taken || !stall) begin
            r_pc          <= branch_taken ? branch_target : w_pc_plus4;
            r_instruction <= RV32I_NOP;
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b1;
            r_state       <= FETCH;
          end
        end

        DRAIN: begin
          if (w_misaligned) begin
            r_state            <= FAULT;
            r_pc               <= branch_target;
            r_fault            <= 1'b1;
            r_instr_valid      <= 1'b0;
            r_imem_req         <= 1'b0;
            r_redirect_pending <= 1'b0;
          end else if (imem_ack) begin
            r_pc               <= branch_taken ? branch_target : r_redirect_target;
            r_redirect_pending <= 1'b0;
            r_imem_req         <= 1'b1;
            r_state            <= FETCH;
          end else if (branch_taken) begin
            r_redirect_target <= branch_target;
            r_imem_req        <= 1'b1;
          end else if (w_timeout) begin
            r_state            <= FAULT;
            r_fault            <= 1'b1;
            r_instr_valid      <= 1'b0;
            r_imem_req         <= 1'b0;
            r_redirect_pending <= 1'b0;
          end else begin
            r_imem_req <= 1'b1;
          end
        end

        FAULT: begin
          r_fault       <= 1'b1;
          r_instr_valid <= 1'b0;
          r_imem_req    <= 1'b0;
        end

        default: begin
          r_state <= FETCH;
        end
      endcase
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign instruction = r_instruction;
  assign instr_valid = r_instr_valid;
  assign fault       = r_fault;

endmodule

`default_nettype wire
